// File: rtl/quad_split_overlay.sv
// quad_split_overlay: draws a 2x2 quad-view border and no-signal fill over RGB565 video, 1-cycle latency
//   I_clk/I_rst                 : video clock, synchronous active-high reset
//   I_en                        : 1 = overlay on, 0 = pass-through
//   I_nosig                     : per-quadrant no-signal flags (bit0 TL, bit1 TR, bit2 BL, bit3 BR)
//   I_vid_vs/I_vid_de/I_vid_data: input video timing and RGB565 pixel
//   O_vid_vs/O_vid_de/O_vid_data: registered, overlaid video
//   O_line_err/O_frame_err      : single-cycle pulses on wrong line length / line count
module quad_split_overlay #(
    parameter int          H_ACTIVE    = 1024,
    parameter int          V_ACTIVE    = 768,
    parameter int          LINE_W      = 2,
    parameter logic [15:0] LINE_COLOR  = 16'hFFFF,
    parameter logic [15:0] NOSIG_COLOR = 16'h001F
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_en,
    input  logic [3:0]  I_nosig,
    input  logic        I_vid_vs,
    input  logic        I_vid_de,
    input  logic [15:0] I_vid_data,
    output logic        O_vid_vs,
    output logic        O_vid_de,
    output logic [15:0] O_vid_data,
    output logic        O_line_err,
    output logic        O_frame_err
);
    localparam logic [10:0] XA  = 11'(H_ACTIVE);
    localparam logic [10:0] YA  = 11'(V_ACTIVE);
    localparam logic [10:0] LW  = 11'(LINE_W);
    localparam logic [10:0] XE  = 11'(H_ACTIVE - LINE_W);
    localparam logic [10:0] YE  = 11'(V_ACTIVE - LINE_W);
    localparam logic [10:0] XH  = 11'(H_ACTIVE / 2);
    localparam logic [10:0] YH  = 11'(V_ACTIVE / 2);
    localparam logic [10:0] XM0 = 11'(H_ACTIVE / 2 - LINE_W / 2);
    localparam logic [10:0] XM1 = 11'(H_ACTIVE / 2 + LINE_W / 2);
    localparam logic [10:0] YM0 = 11'(V_ACTIVE / 2 - LINE_W / 2);
    localparam logic [10:0] YM1 = 11'(V_ACTIVE / 2 + LINE_W / 2);
    logic [10:0] x, y;
    logic [3:0]  nosig_q;
    logic        frame_seen;
    logic        vs_rise, de_fall, border;
    logic [1:0]  q;
    logic [15:0] pix;
    // The registered vs/de outputs double as the previous-cycle copies for edge detection
    assign vs_rise = I_vid_vs & ~O_vid_vs;
    assign de_fall = O_vid_de & ~I_vid_de;
    // x/y hold the position of the current pixel: the counters advance after it is classified
    assign border = x < LW || x >= XE || y < LW || y >= YE ||
                    (x >= XM0 && x < XM1) || (y >= YM0 && y < YM1);
    assign q = {y >= YH, x >= XH};
    assign pix = (!I_en || !I_vid_de) ? I_vid_data :
                 border               ? LINE_COLOR :
                 nosig_q[q]           ? NOSIG_COLOR : I_vid_data;
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_vid_vs    <= 1'b0;
            O_vid_de    <= 1'b0;
            O_vid_data  <= 16'h0000;
            O_line_err  <= 1'b0;
            O_frame_err <= 1'b0;
            x           <= '0;
            y           <= '0;
            nosig_q     <= '0;
            frame_seen  <= 1'b0;
        end else begin
            O_vid_vs    <= I_vid_vs;
            O_vid_de    <= I_vid_de;
            O_vid_data  <= pix;
            O_line_err  <= de_fall && x != XA;
            O_frame_err <= vs_rise && frame_seen && y != YA;
            if (vs_rise) begin
                x          <= '0;
                y          <= '0;
                nosig_q    <= I_nosig;
                frame_seen <= 1'b1;
            end else if (de_fall) begin
                x <= '0;
                y <= (y == 11'h7FF) ? y : y + 11'd1;
            end else if (I_vid_de && x != 11'h7FF) begin
                x <= x + 11'd1;
            end
        end
    end
endmodule

// File: tb/tb_quad_split_overlay.sv
// tb_quad_split_overlay: directed checks of the quad overlay on a reduced 64x48 raster
module tb_quad_split_overlay;
    localparam int H = 64;
    localparam int V = 48;
    logic        clk = 1'b0;
    logic        rst, en, vs, de;
    logic [3:0]  nosig;
    logic [15:0] data;
    logic        o_vs, o_de, o_lerr, o_ferr;
    logic [15:0] o_data;
    logic [15:0] cap [0:V-1][0:H-1];
    int          errors = 0, checks = 0;
    int          lerr = 0, ferr = 0, lerr_at = -1, fall_t = -2, tcount = 0, passerr = 0, synerr = 0;
    int          cx = 0, cy = 0, pcx, pcy;
    logic        pvs, pde, prst, pen, usepat = 1'b0;
    logic [15:0] pdata, base = 16'h1234;

    quad_split_overlay #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_W(2)) dut (
        .I_clk(clk), .I_rst(rst), .I_en(en), .I_nosig(nosig),
        .I_vid_vs(vs), .I_vid_de(de), .I_vid_data(data),
        .O_vid_vs(o_vs), .O_vid_de(o_de), .O_vid_data(o_data),
        .O_line_err(o_lerr), .O_frame_err(o_ferr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pix(input int px, input int py);
        return usepat ? 16'((py * 64 + px) ^ 32'hA5A5) : base;
    endfunction

    // One clock: inputs set before the edge are checked against the outputs 1 ns after it
    task automatic tick;
        pvs = vs; pde = de; pdata = data; prst = rst; pen = en; pcx = cx; pcy = cy;
        @(posedge clk);
        #1;
        tcount++;
        if (!prst) begin
            if (o_vs !== pvs || o_de !== pde) synerr++;
            if (pde && pcx < H && pcy < V) cap[pcy][pcx] = o_data;
            if ((!pde || !pen) && o_data !== pdata) passerr++;
            if (o_lerr === 1'b1) begin lerr++; lerr_at = tcount; end
            if (o_ferr === 1'b1) ferr++;
        end
    endtask

    task automatic lines(input int y0, input int n, input int short_y);
        for (int l = y0; l < y0 + n; l++) begin
            for (int i = 0; i < ((l == short_y) ? H - 1 : H); i++) begin
                de = 1'b1; cx = i; cy = l; data = pix(i, l);
                tick;
            end
            de = 1'b0;
            if (l == short_y) fall_t = tcount + 1;
            for (int b = 0; b < 4; b++) begin
                data = 16'h5A5A ^ 16'(l * 7 + b);
                tick;
            end
        end
    endtask

    task automatic vsync;
        de = 1'b0; vs = 1'b1;
        tick;
        vs = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; nosig = 4'b0000; vs = 1'b1; de = 1'b1; data = 16'hABCD;
        tick;
        tick;
        checks++; if (o_vs !== 1'b0) begin errors++; $display("FAIL reset_vs: got %b want 0", o_vs); end
        checks++; if (o_de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", o_de); end
        checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", o_data); end
        checks++; if (o_lerr !== 1'b0) begin errors++; $display("FAIL reset_lerr: got %b want 0", o_lerr); end
        checks++; if (o_ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", o_ferr); end
        rst = 1'b0; vs = 1'b0; de = 1'b0; data = 16'h0000;
        tick;
    endtask

    task automatic test_nominal;
        usepat = 1'b0; base = 16'h1234; lerr = 0; ferr = 0;
        lines(0, 40, -1);
        vsync;
        checks++; if (ferr !== 0) begin errors++; $display("FAIL first_vs_ferr: got %0d pulses want 0", ferr); end
        lines(0, V, -1);
        checks++; if (cap[0][0] !== 16'hFFFF) begin errors++; $display("FAIL px_0_0: got %h want ffff", cap[0][0]); end
        checks++; if (cap[10][31] !== 16'hFFFF) begin errors++; $display("FAIL px_31_10: got %h want ffff", cap[10][31]); end
        checks++; if (cap[10][32] !== 16'hFFFF) begin errors++; $display("FAIL px_32_10: got %h want ffff", cap[10][32]); end
        checks++; if (cap[10][10] !== 16'h1234) begin errors++; $display("FAIL px_10_10: got %h want 1234", cap[10][10]); end
        checks++; if (cap[2][2] !== 16'h1234) begin errors++; $display("FAIL px_2_2: got %h want 1234", cap[2][2]); end
        checks++; if (cap[1][5] !== 16'hFFFF) begin errors++; $display("FAIL px_5_1: got %h want ffff", cap[1][5]); end
        checks++; if (cap[45][61] !== 16'h1234) begin errors++; $display("FAIL px_61_45: got %h want 1234", cap[45][61]); end
        checks++; if (cap[46][20] !== 16'hFFFF) begin errors++; $display("FAIL px_20_46: got %h want ffff", cap[46][20]); end
        checks++; if (cap[20][62] !== 16'hFFFF) begin errors++; $display("FAIL px_62_20: got %h want ffff", cap[20][62]); end
        checks++; if (lerr !== 0) begin errors++; $display("FAIL nominal_lerr: got %0d pulses want 0", lerr); end
    endtask

    task automatic test_frame_len;
        vsync;
        checks++; if (ferr !== 0) begin errors++; $display("FAIL good_frame_ferr: got %0d pulses want 0", ferr); end
        lines(0, V - 1, -1);
        vsync;
        checks++; if (ferr !== 1) begin errors++; $display("FAIL short_frame_ferr: got %0d pulses want 1", ferr); end
        lines(0, V, -1);
    endtask

    task automatic test_nosig;
        nosig = 4'b1000;
        vsync;
        lines(0, 26, -1);
        nosig = 4'b0000;
        lines(26, V - 26, -1);
        checks++; if (cap[30][40] !== 16'h001F) begin errors++; $display("FAIL nosig_40_30: got %h want 001f", cap[30][40]); end
        checks++; if (cap[24][40] !== 16'hFFFF) begin errors++; $display("FAIL nosig_40_24: got %h want ffff", cap[24][40]); end
        checks++; if (cap[40][40] !== 16'h001F) begin errors++; $display("FAIL nosig_persist: got %h want 001f", cap[40][40]); end
        checks++; if (cap[30][10] !== 16'h1234) begin errors++; $display("FAIL nosig_q2: got %h want 1234", cap[30][10]); end
        checks++; if (cap[10][40] !== 16'h1234) begin errors++; $display("FAIL nosig_q1: got %h want 1234", cap[10][40]); end
    endtask

    task automatic test_line_err;
        vsync;
        checks++; if (ferr !== 1) begin errors++; $display("FAIL nosig_frame_ferr: got %0d pulses want 1", ferr); end
        lerr = 0;
        lines(0, V, 5);
        checks++; if (lerr !== 1) begin errors++; $display("FAIL line_err_count: got %0d pulses want 1", lerr); end
        checks++; if (lerr_at !== fall_t) begin errors++; $display("FAIL line_err_timing: got tick %0d want %0d", lerr_at, fall_t); end
    endtask

    task automatic test_reset_mid;
        vsync;
        checks++; if (ferr !== 1) begin errors++; $display("FAIL lerr_frame_ferr: got %0d pulses want 1", ferr); end
        lines(0, 20, -1);
        rst = 1'b1; de = 1'b1; data = 16'h1234;
        tick;
        checks++; if (o_vs !== 1'b0) begin errors++; $display("FAIL mid_reset_vs: got %b want 0", o_vs); end
        checks++; if (o_de !== 1'b0) begin errors++; $display("FAIL mid_reset_de: got %b want 0", o_de); end
        checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL mid_reset_data: got %h want 0000", o_data); end
        checks++; if (o_lerr !== 1'b0) begin errors++; $display("FAIL mid_reset_lerr: got %b want 0", o_lerr); end
        checks++; if (o_ferr !== 1'b0) begin errors++; $display("FAIL mid_reset_ferr: got %b want 0", o_ferr); end
        rst = 1'b0; de = 1'b0;
        tick;
        lines(20, V - 20, -1);
        vsync;
        checks++; if (ferr !== 1) begin errors++; $display("FAIL after_reset_ferr: got %0d pulses want 1", ferr); end
    endtask

    task automatic test_bypass;
        usepat = 1'b1; en = 1'b0; nosig = 4'b1111;
        lines(0, V, -1);
        vsync;
        lines(0, 30, -1);
        en = 1'b1;
        lines(30, V - 30, -1);
        checks++; if (cap[0][0] !== pix(0, 0)) begin errors++; $display("FAIL bypass_0_0: got %h want %h", cap[0][0], pix(0, 0)); end
        checks++; if (cap[29][40] !== pix(40, 29)) begin errors++; $display("FAIL bypass_40_29: got %h want %h", cap[29][40], pix(40, 29)); end
        checks++; if (cap[30][40] !== 16'h001F) begin errors++; $display("FAIL en_on_40_30: got %h want 001f", cap[30][40]); end
        checks++; if (cap[30][32] !== 16'hFFFF) begin errors++; $display("FAIL en_on_32_30: got %h want ffff", cap[30][32]); end
        vsync;
        checks++; if (ferr !== 1) begin errors++; $display("FAIL final_ferr: got %0d pulses want 1", ferr); end
        checks++; if (passerr !== 0) begin errors++; $display("FAIL passthrough: got %0d bad cycles want 0", passerr); end
        checks++; if (synerr !== 0) begin errors++; $display("FAIL vs_de_delay: got %0d bad cycles want 0", synerr); end
        checks++; if (lerr !== 1) begin errors++; $display("FAIL total_lerr: got %0d pulses want 1", lerr); end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_frame_len;
        test_nosig;
        test_line_err;
        test_reset_mid;
        test_bypass;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
